// File: rtl/dct_pkg.sv
// dct_pkg: shared widths, Q1.8 cosine constants, FSM states
// and the basis-matrix lookup for the 8-point forward DCT row engine.
package dct_pkg;

    localparam int NPT    = 8;
    localparam int PIX_W  = 8;
    localparam int SMP_W  = 9;
    localparam int COEF_W = 9;
    localparam int PROD_W = SMP_W + COEF_W;
    localparam int ACC_W  = 21;
    localparam int OUT_W  = 11;
    localparam int FRAC   = 9;
    localparam int SHF_W  = ACC_W - FRAC;

    localparam int IN_W   = NPT * PIX_W;
    localparam int ROW_W  = NPT * OUT_W;

    localparam logic signed [COEF_W-1:0] C1 = 9'sd251;
    localparam logic signed [COEF_W-1:0] C2 = 9'sd236;
    localparam logic signed [COEF_W-1:0] C3 = 9'sd213;
    localparam logic signed [COEF_W-1:0] C4 = 9'sd181;
    localparam logic signed [COEF_W-1:0] C5 = 9'sd142;
    localparam logic signed [COEF_W-1:0] C6 = 9'sd98;
    localparam logic signed [COEF_W-1:0] C7 = 9'sd50;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef logic signed [SMP_W-1:0]  smp_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [OUT_W-1:0]  out_t;

    // cos(i*pi/16) for i = 1..7; index 0 is never requested.
    function automatic coef_t cval(input logic [2:0] idx);
        coef_t c;
        case (idx)
            3'd1:    c = C1;
            3'd2:    c = C2;
            3'd3:    c = C3;
            3'd4:    c = C4;
            3'd5:    c = C5;
            3'd6:    c = C6;
            3'd7:    c = C7;
            default: c = '0;
        endcase
        return c;
    endfunction

    // M[k][n]: fold the angle k*(2n+1)*pi/16 into [0, pi]
    // and pick the matching cosine with its sign.
    function automatic coef_t coef(input logic [2:0] k,
                                   input logic [2:0] n);
        logic [6:0] p;
        logic [5:0] m;
        logic [5:0] r;
        coef_t      c;
        p = {4'b0, k} * {3'b0, n, 1'b1};
        m = {1'b0, p[4:0]};
        if (m > 6'd16) begin
            m = 6'd32 - m;
        end
        r = 6'd16 - m;
        if (k == 3'd0) begin
            c = C4;
        end else if (m < 6'd8) begin
            c = cval(m[2:0]);
        end else begin
            c = -cval(r[2:0]);
        end
        return c;
    endfunction

endpackage

// File: rtl/dct_row_mac.sv
// dct_row_mac: one DCT coefficient from eight level-shifted samples
// and one basis row; purely combinational dot product, round, clamp.
module dct_row_mac
    import dct_pkg::*;
(
    input  smp_t  s_i [NPT],
    input  coef_t c_i [NPT],
    output out_t  x_o
);

    localparam logic signed [SHF_W-1:0] HI = 12'sd1023;
    localparam logic signed [SHF_W-1:0] LO = -12'sd1024;
    localparam logic signed [ACC_W-1:0] HALF = 21'sd256;

    logic signed [PROD_W-1:0] prod [NPT];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [SHF_W-1:0]  shf;

    // Signed dot product; 8 x 18-bit terms cannot overflow 21 bits.
    always_comb begin
        acc = '0;
        for (int n = 0; n < NPT; n++) begin
            prod[n] = PROD_W'(s_i[n]) * PROD_W'(c_i[n]);
            acc     = acc + ACC_W'(prod[n]);
        end
    end

    // Half-up round; the extra shift bit applies the 1/2 scale.
    always_comb begin
        rnd = acc + HALF;
        shf = SHF_W'(rnd >>> FRAC);
        if (shf > HI) begin
            x_o = out_t'(HI);
        end else if (shf < LO) begin
            x_o = out_t'(LO);
        end else begin
            x_o = shf[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dct_1d_row.sv
// dct_1d_row: forward 8-point DCT row engine; accepts a pixel row,
// computes one coefficient per cycle, presents the packed row.
module dct_1d_row
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_data,
    output logic             busy
);

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    smp_t              s_q [NPT];
    smp_t              s_d [NPT];
    logic [ROW_W-1:0]  out_q, out_d;

    coef_t             c_w [NPT];
    out_t              x_w;

    // Basis row for the coefficient being computed this cycle.
    always_comb begin
        for (int n = 0; n < NPT; n++) begin
            c_w[n] = coef(k_q, 3'(n));
        end
    end

    dct_row_mac u_mac (
        .s_i (s_q),
        .c_i (c_w),
        .x_o (x_w)
    );

    // Next-state, sample capture and coefficient slot writes.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int n = 0; n < NPT; n++) begin
                        s_d[n] = smp_t'({1'b0,
                            in_data[IN_W-1-PIX_W*n -: PIX_W]}
                            - 9'd128);
                    end
                    k_d     = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int j = 0; j < NPT; j++) begin
                    if (k_q == 3'(j)) begin
                        out_d[ROW_W-1-OUT_W*j -: OUT_W] = x_w;
                    end
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, sample and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            s_q     <= '{default: '0};
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_dct_1d_row.sv
// tb_dct_1d_row: directed scenarios for the DCT row engine,
// expected rows hand-derived from the Q1.8 basis and rounding rule.
module tb_dct_1d_row;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [87:0] out_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dct_1d_row dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [87:0] pack8(
        input int x0, input int x1, input int x2, input int x3,
        input int x4, input int x5, input int x6, input int x7);
        return {11'(x0), 11'(x1), 11'(x2), 11'(x3),
                11'(x4), 11'(x5), 11'(x6), 11'(x7)};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [63:0] px, output bit ok);
        int g = 0;
        in_data  = px;
        in_valid = 1'b1;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        rst_n     = 1'b1;
        #2;
        rst_n     = 1'b0;
        tick(2);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (out_data !== 88'h0) begin
            n_bad++;
            $display("FAIL rst_out_data: got %h want 0", out_data);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(3);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_out_ready: got valid=%b busy=%b want 0 0",
                     out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_zero_row();
        bit ok;
        bit bok;
        int cyc;
        send_row({8{8'd128}}, ok);
        n_cmp++;
        if (ok !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_accept: got ok=%b busy=%b want 1 1", ok, busy);
        end
        wait_valid(cyc, bok);
        n_cmp++;
        if (cyc != 8) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d want 8", cyc);
        end
        n_cmp++;
        if (bok !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_busy: got busy low in calc want high");
        end
        n_cmp++;
        if (out_data !== 88'h0) begin
            n_bad++;
            $display("FAIL zero_data: got %h want 0", out_data);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_release: got v=%b b=%b r=%b want 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_dc_rows();
        bit ok;
        bit bok;
        int cyc;
        logic [87:0] exp_d;
        send_row({8{8'd255}}, ok);
        wait_valid(cyc, bok);
        exp_d = pack8(359, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (cyc != 8 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL dc_255: got %h (cyc %0d) want %h (cyc 8)",
                     out_data, cyc, exp_d);
        end
        handshake();
        send_row({8{8'd0}}, ok);
        wait_valid(cyc, bok);
        exp_d = pack8(-362, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (cyc != 8 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL dc_0: got %h (cyc %0d) want %h (cyc 8)",
                     out_data, cyc, exp_d);
        end
        handshake();
    endtask

    task automatic test_impulse();
        bit ok;
        bit bok;
        int cyc;
        logic [87:0] exp_d;
        send_row({8'd255, {7{8'd128}}}, ok);
        wait_valid(cyc, bok);
        exp_d = pack8(45, 62, 59, 53, 45, 35, 24, 12);
        n_cmp++;
        if (cyc != 8 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL impulse0: got %h (cyc %0d) want %h (cyc 8)",
                     out_data, cyc, exp_d);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit bok;
        int cyc;
        logic [87:0] exp_a;
        logic [87:0] exp_b;
        exp_a = pack8(-45, 63, -59, 53, -45, 36, -24, 13);
        exp_b = pack8(359, 0, 0, 0, 0, 0, 0, 0);
        send_row({{7{8'd128}}, 8'd0}, ok);
        wait_valid(cyc, bok);
        n_cmp++;
        if (cyc != 8 || out_data !== exp_a) begin
            n_bad++;
            $display("FAIL b2b_row_a: got %h (cyc %0d) want %h (cyc 8)",
                     out_data, cyc, exp_a);
        end
        in_data  = {8{8'd255}};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (out_data !== exp_a || in_ready !== 1'b0 ||
                out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_hold%0d: got %h r=%b v=%b want %h 0 1",
                         i, out_data, in_ready, out_valid, exp_a);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_handshake: got v=%b r=%b b=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept_b: got busy=%b want 1", busy);
        end
        wait_valid(cyc, bok);
        n_cmp++;
        if (cyc != 8 || out_data !== exp_b) begin
            n_bad++;
            $display("FAIL b2b_row_b: got %h (cyc %0d) want %h (cyc 8)",
                     out_data, cyc, exp_b);
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit bok;
        bit seen;
        int cyc;
        logic [87:0] exp_d;
        send_row({8{8'd0}}, ok);
        tick(3);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: got v=%b r=%b b=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        n_cmp++;
        if (out_data !== 88'h0) begin
            n_bad++;
            $display("FAIL abort_data: got %h want 0", out_data);
        end
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_output: got out_valid=1 want 0");
        end
        send_row({8{8'd255}}, ok);
        wait_valid(cyc, bok);
        exp_d = pack8(359, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (cyc != 8 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL abort_next_row: got %h (cyc %0d) want %h (cyc 8)",
                     out_data, cyc, exp_d);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_zero_row();
        test_dc_rows();
        test_impulse();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
